// File: rtl/wb_copy_master.sv
// Wishbone classic block-copy master: one single read then one single write per word,
// with a per-transaction ack timeout so a silent responder cannot hang the bus.
module wb_copy_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_i,
    input  logic [ADDR_WIDTH-1:0] dst_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [LEN_WIDTH-1:0]  words_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic [3:0]            wb_sel_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] WSTEP    = ADDR_WIDTH'(4);

    typedef enum logic [2:0] {IDLE, READ, GAP_W, WRITE, GAP_R} state_t;

    state_t                state_q, state_d;
    logic                  stb_q, stb_d, we_q, we_d, done_q, done_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d, src_q, src_d, dst_q, dst_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d, words_q, words_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        words_d = words_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_d   = 1'b0;
                    words_d = '0;
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        src_d   = {src_i[ADDR_WIDTH-1:2], 2'b00};
                        dst_d   = {dst_i[ADDR_WIDTH-1:2], 2'b00};
                        rem_d   = len_i;
                        adr_d   = {src_i[ADDR_WIDTH-1:2], 2'b00};
                        stb_d   = 1'b1;
                        we_d    = 1'b0;
                        tmo_d   = '0;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (wb_ack_i) begin
                    dat_d   = wb_dat_i;
                    src_d   = src_q + WSTEP;
                    stb_d   = 1'b0;
                    state_d = GAP_W;
                end else if (tmo_q == TMO_LAST) begin
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            GAP_W: begin
                stb_d   = 1'b1;
                we_d    = 1'b1;
                adr_d   = dst_q;
                tmo_d   = '0;
                state_d = WRITE;
            end
            WRITE: begin
                if (wb_ack_i) begin
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    dst_d   = dst_q + WSTEP;
                    words_d = words_q + LEN_WIDTH'(1);
                    rem_d   = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = GAP_R;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            GAP_R: begin
                stb_d   = 1'b1;
                we_d    = 1'b0;
                adr_d   = src_q;
                tmo_d   = '0;
                state_d = READ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            words_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            words_q <= words_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // cyc and sel are pure functions of the registered strobe, so they are glitch-free too
    assign wb_cyc_o = stb_q;
    assign wb_stb_o = stb_q;
    assign wb_sel_o = {4{stb_q}};
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign words_o  = words_q;
endmodule

// File: tb/tb_wb_copy_master.sv
// Randomized bench for wb_copy_master: memory responder with random ack latency,
// bus monitor, and a word-by-word copy model computed from a memory snapshot.
module tb_wb_copy_master;
    localparam int TMO = 8;

    logic        clk = 1'b0, rst;
    logic        start;
    logic [31:0] src, dst;
    logic [15:0] len_in;
    logic        busy, done, err;
    logic [15:0] words;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_o, dat_i;
    logic [3:0]  sel;
    logic        ack;

    always #5 clk = ~clk;

    wb_copy_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .src_i(src), .dst_i(dst), .len_i(len_in),
        .busy_o(busy), .done_o(done), .err_o(err), .words_o(words),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr), .wb_dat_o(dat_o),
        .wb_sel_o(sel), .wb_dat_i(dat_i), .wb_ack_i(ack)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // memory responder; blk_rd selects a read index that never gets acked
    bit [31:0] mem [bit [31:0]];
    int lat_fix = -1, lat_cur = 0, wait_cnt = 0, blk_rd = -1, rd_done = 0;

    always @(posedge clk) begin
        if (ack) begin
            ack <= 1'b0;
        end else if (stb) begin
            if (!we && blk_rd == rd_done) begin
                wait_cnt = 0;
            end else if (wait_cnt >= lat_cur) begin
                ack <= 1'b1;
                wait_cnt = 0;
                if (we) mem[adr] = dat_o;
                else begin
                    dat_i <= mem.exists(adr) ? mem[adr] : 32'h0;
                    rd_done++;
                end
                lat_cur = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // bus monitor
    typedef struct {bit we; bit [31:0] adr; bit [31:0] dat;} txn_t;
    txn_t obs_q[$];
    int proto_bad = 0, gap_bad = 0, cyc_seen = 0, busy_seen = 0, done_cnt = 0;
    int run = 0, last_run = 0, low_run = 0;
    bit prev_stb = 0, prev_ack = 0, prev_we = 0;
    bit [31:0] prev_adr = 0, prev_dat = 0;

    always @(posedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_seen++;
        if (cyc) cyc_seen++;
        if (cyc !== stb) proto_bad++;
        if (sel !== (stb ? 4'hF : 4'h0)) proto_bad++;
        if (stb) begin
            if (prev_stb && prev_ack) gap_bad++;
            if (prev_stb && !prev_ack &&
                (adr !== prev_adr || we !== prev_we || (we && dat_o !== prev_dat))) proto_bad++;
            if (!prev_stb && low_run > 1) gap_bad++;
            low_run = 0;
            run++;
            if (ack) obs_q.push_back('{we, adr, we ? dat_o : dat_i});
        end else begin
            if (prev_stb) last_run = run;
            run = 0;
            if (busy) low_run++;
            else low_run = 0;
        end
        prev_stb = stb; prev_ack = ack; prev_we = we; prev_adr = adr; prev_dat = dat_o;
    end

    // copy model: word-by-word over a snapshot of memory, so overlapping ranges behave as the bus would
    task automatic run_copy(input string nm, input bit [31:0] s, input bit [31:0] d,
                            input int len, input int blk, input bit poke);
        bit [31:0] rm [bit [31:0]];
        txn_t exp_q[$];
        bit [31:0] sa, da, w;
        int exp_words, d0, n;
        bit exp_err, got_done;
        rm = mem;
        sa = s & ~32'h3;
        da = d & ~32'h3;
        exp_words = len;
        exp_err = 0;
        for (int i = 0; i < len; i++) begin
            if (i == blk) begin exp_words = i; exp_err = 1; break; end
            w = rm[sa + 32'(4 * i)];
            exp_q.push_back('{1'b0, sa + 32'(4 * i), w});
            rm[da + 32'(4 * i)] = w;
            exp_q.push_back('{1'b1, da + 32'(4 * i), w});
        end
        obs_q.delete();
        rd_done = 0;
        blk_rd = blk;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len_in = 16'(len);
        got_done = 0;
        for (int c = 0; c < 4000 && !got_done; c++) begin
            @(negedge clk);
            if (poke && c == 4) begin
                start = 1'b1; src = 32'h1F00; dst = 32'h1F80; len_in = 16'd7;
            end else start = 1'b0;
            if (done) got_done = 1;
        end
        start = 1'b0;
        chk({nm, "_done_seen"}, 64'(got_done), 64'd1);
        chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({nm, "_words"}, 64'(words), 64'(exp_words));
        chk({nm, "_err"}, 64'(err), 64'(exp_err));
        @(negedge clk);
        chk({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        chk({nm, "_done_low"}, 64'(done), 64'd0);
        chk({nm, "_txn_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_txn%0d_we_adr", nm, i), {31'd0, obs_q[i].we, obs_q[i].adr},
                {31'd0, exp_q[i].we, exp_q[i].adr});
            chk($sformatf("%s_txn%0d_dat", nm, i), 64'(obs_q[i].dat), 64'(exp_q[i].dat));
        end
        for (int i = 0; i < exp_words; i++)
            chk($sformatf("%s_mem%0d", nm, i), 64'(mem[da + 32'(4 * i)]), 64'(rm[da + 32'(4 * i)]));
        blk_rd = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cs, cb, d0;
        bit found;
        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len_in = '0; ack = 1'b0; dat_i = '0;
        for (int a = 0; a < 32'h3000; a += 4) mem[32'(a)] = $urandom;
        #3;
        chk("reset_ctl", {57'd0, cyc, stb, we, busy, done, err, |sel}, 64'd0);
        chk("reset_adr", 64'(adr), 64'd0);
        chk("reset_dat", 64'(dat_o), 64'd0);
        chk("reset_words", 64'(words), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        mem[32'h100] = 32'hDEADBEEF;
        lat_fix = 2;
        run_copy("single", 32'h100, 32'h200, 1, -1, 0);
        chk("single_mem", 64'(mem[32'h200]), 64'hDEADBEEF);

        lat_fix = -1;
        run_copy("four", 32'h0, 32'h1000, 4, -1, 0);
        run_copy("unaligned", 32'h103, 32'h2FE, 2, -1, 0);
        run_copy("overlap", 32'h40, 32'h48, 5, -1, 0);
        run_copy("poke", 32'h300, 32'h900, 4, -1, 1);
        for (int k = 0; k < 6; k++) begin
            int l;
            l = int'($urandom_range(1, 6));
            run_copy($sformatf("rand%0d", k), {22'd0, 8'($urandom), 2'($urandom)},
                     32'h800 + {22'd0, 8'($urandom), 2'd0}, l, -1, l >= 3);
        end

        run_copy("timeout", 32'h500, 32'hA00, 3, 1, 0);
        chk("timeout_stb_run", 64'(last_run), 64'(TMO));

        // zero-length start: also clears the sticky error
        cs = cyc_seen; cb = busy_seen; d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; src = 32'h0; dst = 32'h10; len_in = 16'd0;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_err_clr", 64'(err), 64'd0);
        chk("zero_words", 64'(words), 64'd0);
        @(negedge clk);
        chk("zero_done_low", 64'(done), 64'd0);
        @(negedge clk);
        chk("zero_no_cyc", 64'(cyc_seen - cs), 64'd0);
        chk("zero_no_busy", 64'(busy_seen - cb), 64'd0);
        chk("zero_pulses", 64'(done_cnt - d0), 64'd1);

        // reset while a write is pending
        lat_fix = 3;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; src = 32'h600; dst = 32'hC00; len_in = 16'd2;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (stb && we) found = 1;
            else @(negedge clk);
        end
        chk("rst_reached_write", 64'(found), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_bus", {61'd0, cyc, stb, we}, 64'd0);
        chk("rst_async_busy", 64'(busy), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("rst_idle", 64'(busy), 64'd0);
        lat_fix = -1;
        run_copy("after_rst", 32'h600, 32'hC00, 2, -1, 0);

        chk("protocol_errors", 64'(proto_bad), 64'd0);
        chk("gap_errors", 64'(gap_bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
